// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared SECDED sizing helpers and error classification type
package hamming_pkg;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_CORR,
        ERR_UNCORR
    } err_kind_t;

    function automatic int par_w(input int data_w);
        for (int r = 1; r < 16; r++) begin
            if ((1 << r) >= data_w + r + 1) return r;
        end
        return 16;
    endfunction

    function automatic int cw_w(input int data_w);
        return data_w + par_w(data_w) + 1;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Codeword position holding data bit idx: the idx-th non-power-of-two position from 1 upward.
    function automatic int data_pos(input int idx);
        int k;
        k = 0;
        for (int p = 1; p < 256; p++) begin
            if (!is_pow2(p)) begin
                if (k == idx) return p;
                k++;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - combinational Hamming syndrome and overall parity of a codeword
module hamming_syndrome #(
    parameter int CW_W  = 8,
    parameter int PAR_W = 3
) (
    input  logic [CW_W-1:0]  i_codeword,
    output logic [PAR_W-1:0] o_syndrome,
    output logic             o_parity
);

    always_comb begin
        o_syndrome = '0;
        for (int p = 1; p < CW_W; p++) begin
            if (i_codeword[p]) o_syndrome = o_syndrome ^ PAR_W'(p);
        end
        o_parity = ^i_codeword;
    end

endmodule

// File: rtl/hamming_secded_decoder.sv
// rtl/hamming_secded_decoder.sv - two-stage SECDED decoder with valid/ready on both sides
// Optional error counters enabled by defining HAMMING_ERR_COUNT_EN.
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int PAR_W   = par_w(DATA_W),
    parameter int CW_W    = cw_w(DATA_W),
    parameter int COUNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW_W-1:0]   in_codeword,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_corrected,
    output logic              out_uncorrectable,
    output logic              out_valid,
    input  logic              out_ready
`ifdef HAMMING_ERR_COUNT_EN
    ,
    input  logic              cnt_clear,
    output logic [COUNT_W-1:0] corr_count,
    output logic [COUNT_W-1:0] uncorr_count
`endif
);

    logic              r_s1_valid;
    logic [CW_W-1:0]   r_s1_cw;
    logic [PAR_W-1:0]  r_s1_syn;
    logic              r_s1_par;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [PAR_W-1:0]  r_out_syn;
    logic              r_out_corr;
    logic              r_out_unc;

    logic [PAR_W-1:0]  w_syn;
    logic              w_par;
    logic              w_s1_load;
    logic              w_s2_load;
    logic [CW_W-1:0]   w_fixed;
    logic [DATA_W-1:0] w_data;
    err_kind_t         w_kind;

    hamming_syndrome #(
        .CW_W  (CW_W),
        .PAR_W (PAR_W)
    ) u_syndrome (
        .i_codeword (in_codeword),
        .o_syndrome (w_syn),
        .o_parity   (w_par)
    );

    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= '0;
            r_s1_syn   <= '0;
            r_s1_par   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            r_s1_cw    <= in_codeword;
            r_s1_syn   <= w_syn;
            r_s1_par   <= w_par;
        end
    end

    // Only an odd-parity word with an in-range, nonzero syndrome gets a bit flipped.
    always_comb begin
        w_kind  = ERR_NONE;
        w_fixed = r_s1_cw;
        if (r_s1_par) begin
            if (int'(r_s1_syn) < CW_W) begin
                w_kind = ERR_CORR;
                for (int p = 1; p < CW_W; p++) begin
                    if (r_s1_syn == PAR_W'(p)) w_fixed[p] = ~r_s1_cw[p];
                end
            end else begin
                w_kind = ERR_UNCORR;
            end
        end else if (r_s1_syn != '0) begin
            w_kind = ERR_UNCORR;
        end
    end

    for (genvar k = 0; k < DATA_W; k++) begin : g_extract
        assign w_data[k] = w_fixed[data_pos(k)];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_syn   <= '0;
            r_out_corr  <= 1'b0;
            r_out_unc   <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_data <= w_data;
                r_out_syn  <= r_s1_syn;
                r_out_corr <= (w_kind == ERR_CORR);
                r_out_unc  <= (w_kind == ERR_UNCORR);
            end
        end
    end

    assign out_valid         = r_out_valid;
    assign out_data          = r_out_data;
    assign out_syndrome      = r_out_syn;
    assign out_corrected     = r_out_corr;
    assign out_uncorrectable = r_out_unc;

`ifdef HAMMING_ERR_COUNT_EN
    logic               w_xfer;
    logic [COUNT_W-1:0] r_corr_cnt;
    logic [COUNT_W-1:0] r_uncorr_cnt;

    assign w_xfer = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            if (w_xfer && r_out_corr && (r_corr_cnt != '1)) r_corr_cnt <= r_corr_cnt + 1'b1;
            if (w_xfer && r_out_unc && (r_uncorr_cnt != '1)) r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
        end
    end

    assign corr_count   = r_corr_cnt;
    assign uncorr_count = r_uncorr_cnt;
`endif

endmodule
